// File: rtl/test_controller.sv
// Purpose : sequences a CPU under test (reset hold, run, drain, halt) and latches the verdict.
// Latency : verdict registered on the edge that samples the terminating event; stop DRAIN_CYCLES edges later.
// Backpress: none; inputs are sampled every cycle and events outside RUN are ignored.
//
// Ports:
//   clk, reset (async, active-low)     -- controller clock and reset
//   trap[NTRAP]                        -- CPU trap levels, rising edge terminates the run
//   dwrite_en/dwrite_addr/dwrite_data  -- CPU data-memory write; a write to EXIT_ADDR ends the run
//   cpu_reset, stop, done, pass, fail  -- control and terminal status levels
//   status, exit_code, trap_id         -- verdict detail, frozen after first termination
//   cycle_count                        -- RUN cycles elapsed, saturating
module test_controller #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int NTRAP          = 1,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 40,
  parameter int DRAIN_CYCLES   = 1,
  parameter logic [ADDR_WIDTH-1:0] EXIT_ADDR = ADDR_WIDTH'(16'hFFFE),
  parameter int CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NTRAP-1:0]      trap,
  input  logic                  dwrite_en,
  input  logic [ADDR_WIDTH-1:0] dwrite_addr,
  input  logic [DATA_WIDTH-1:0] dwrite_data,
  output logic                  cpu_reset,
  output logic                  stop,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [1:0]            status,
  output logic [DATA_WIDTH-1:0] exit_code,
  output logic [3:0]            trap_id,
  output logic [CNT_WIDTH-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10,
    HALT  = 2'b11
  } state_t;

  localparam logic [1:0] ST_EXIT    = 2'b01;
  localparam logic [1:0] ST_TRAP    = 2'b10;
  localparam logic [1:0] ST_TIMEOUT = 2'b11;

  // Counters only ever need to reach (N-1); keep at least one bit.
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t                 state;
  logic [HW-1:0]          hold_cnt;
  logic [DW-1:0]          drain_cnt;
  logic [NTRAP-1:0]       trap_prev;
  logic [NTRAP-1:0]       trap_rise;
  logic [3:0]             rise_id;
  logic                   exit_hit;
  logic                   timeout_hit;
  logic [CNT_WIDTH-1:0]   cnt_inc;

  always_comb begin
    trap_rise = trap & ~trap_prev;
    // Descending scan so the lowest firing index is the one left standing.
    rise_id = '0;
    for (int i = NTRAP - 1; i >= 0; i--) begin
      if (trap_rise[i]) rise_id = 4'(i);
    end
    exit_hit    = dwrite_en && (dwrite_addr == EXIT_ADDR);
    cnt_inc     = (&cycle_count) ? cycle_count : cycle_count + CNT_WIDTH'(1);
    // Compared against the post-increment value so fail rises together with count==TIMEOUT.
    timeout_hit = (cnt_inc >= CNT_WIDTH'(TIMEOUT_CYCLES));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HOLD;
      hold_cnt    <= '0;
      drain_cnt   <= '0;
      trap_prev   <= '0;
      cpu_reset   <= 1'b1;
      stop        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      status      <= 2'b00;
      exit_code   <= '0;
      trap_id     <= '0;
      cycle_count <= '0;
    end else begin
      // History tracks in every state so a level already high at RUN entry is not an edge.
      trap_prev <= trap;
      case (state)
        HOLD: begin
          cpu_reset <= 1'b1;
          if (hold_cnt == HW'(RESET_CYCLES - 1)) begin
            state     <= RUN;
            cpu_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RUN: begin
          cycle_count <= cnt_inc;
          if ((|trap_rise) || exit_hit || timeout_hit) begin
            done      <= 1'b1;
            drain_cnt <= '0;
            if (|trap_rise) begin
              status  <= ST_TRAP;
              fail    <= 1'b1;
              trap_id <= rise_id;
            end else if (exit_hit) begin
              status    <= ST_EXIT;
              exit_code <= dwrite_data;
              pass      <= (dwrite_data == '0);
              fail      <= (dwrite_data != '0);
            end else begin
              status <= ST_TIMEOUT;
              fail   <= 1'b1;
            end
            if (DRAIN_CYCLES == 0) begin
              state     <= HALT;
              stop      <= 1'b1;
              cpu_reset <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // CPU keeps running here so in-flight activity can settle before the halt.
          if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
            state     <= HALT;
            stop      <= 1'b1;
            cpu_reset <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        HALT: begin
          stop      <= 1'b1;
          cpu_reset <= 1'b1;
        end
        default: begin
          state     <= HALT;
          status    <= ST_TIMEOUT;
          pass      <= 1'b0;
          fail      <= 1'b1;
          done      <= 1'b1;
          stop      <= 1'b1;
          cpu_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/test_controller.md
TEST_CONTROLLER -- requirements
Module: test_controller

Interface
REQ-001 SHALL take parameter ADDR_WIDTH, default 16, data-memory address width.
REQ-002 SHALL take parameter DATA_WIDTH, default 16, data-memory write-data width.
REQ-003 SHALL take parameter NTRAP, default 1, number of trap channels (1..16).
REQ-004 SHALL take parameter RESET_CYCLES, default 2, CPU reset hold length in cycles (>=1).
REQ-005 SHALL take parameter TIMEOUT_CYCLES, default 40, RUN cycles allowed before timeout (>=1).
REQ-006 SHALL take parameter DRAIN_CYCLES, default 1, cycles between termination and stop (>=0).
REQ-007 SHALL take parameter EXIT_ADDR, default 16'hFFFE, address whose write ends the test.
REQ-008 SHALL take parameter CNT_WIDTH, default 32, cycle counter width.
REQ-009 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-010 SHALL have port reset  input  1  asynchronous, active-low controller reset.
REQ-011 SHALL have port trap  input  NTRAP  per-channel CPU trap level.
REQ-012 SHALL have port dwrite_en  input  1  data-memory write strobe.
REQ-013 SHALL have port dwrite_addr  input  ADDR_WIDTH  data-memory write address.
REQ-014 SHALL have port dwrite_data  input  DATA_WIDTH  data-memory write data.
REQ-015 SHALL have port cpu_reset  output  1  active-high reset to CPU.
REQ-016 SHALL have port stop  output  1  level, simulation/clock may halt.
REQ-017 SHALL have port done, pass, fail  output  1 each  terminal status levels.
REQ-018 SHALL have port status  output  2  00 none, 01 exit, 10 trap, 11 timeout.
REQ-019 SHALL have port exit_code  output  DATA_WIDTH  data of the terminating EXIT_ADDR write.
REQ-020 SHALL have port trap_id  output  4  lowest-index trap channel that fired.
REQ-021 SHALL have port cycle_count  output  CNT_WIDTH  RUN cycles elapsed, saturating.

Function
REQ-022 SHALL implement states HOLD, RUN, DRAIN, HALT; binary-encoded; illegal codes go to HALT with status 11.
REQ-023 HOLD: cpu_reset=1; hold counter counts RESET_CYCLES cycles, then -> RUN; cpu_reset deasserts on the same edge.
REQ-024 RUN: cycle_count increments by 1 per cycle, saturating at all-ones; cpu_reset=0.
REQ-025 Trap detection SHALL be rising-edge per channel (registered previous level, previous cleared by reset); a level already high on entry to RUN does not fire.
REQ-026 In RUN, trap edge -> DRAIN, status=10, fail=1, trap_id=lowest firing index.
REQ-027 In RUN, dwrite_en with dwrite_addr==EXIT_ADDR -> DRAIN, status=01, exit_code=dwrite_data; pass=1 iff dwrite_data==0, else fail=1.
REQ-028 In RUN, cycle_count reaching TIMEOUT_CYCLES with no other event -> DRAIN, status=11, fail=1.
REQ-029 Same-cycle priority: trap > exit write > timeout; only the winner is recorded.
REQ-030 DRAIN: counts DRAIN_CYCLES cycles then -> HALT; DRAIN_CYCLES=0 goes straight to HALT from RUN; CPU keeps running.
REQ-031 HALT: stop=1, cpu_reset=1; terminal until reset.
REQ-032 done SHALL be 1 in DRAIN and HALT; pass, fail, status, exit_code, trap_id frozen after first termination.
REQ-033 Trap edges, exit writes and timeout SHALL be ignored in HOLD, DRAIN and HALT.
REQ-034 cycle_count SHALL stop incrementing on leaving RUN.

Reset
REQ-035 reset low SHALL asynchronously force HOLD, cpu_reset=1, stop=0, done=0, pass=0, fail=0, status=00, exit_code=0, trap_id=0, cycle_count=0, counters and trap history cleared.
REQ-036 Reset asserted mid-RUN or mid-DRAIN SHALL abandon the test; deassertion restarts from HOLD.
REQ-037 Outputs SHALL be registered; no combinational path input -> output.

Verification
REQ-038 Defaults, reset low 2 cycles then high -> cpu_reset high 2 edges, falls; cycle_count counts 1,2,3...
REQ-039 Write 0x0000 to 0xFFFE at RUN cycle 10 -> status=01, pass=1, exit_code=0, done next edge, stop 1 cycle later, cycle_count frozen at 10.
REQ-040 NTRAP=4, trap[2] and trap[1] rise same cycle as an exit write -> status=10, fail=1, trap_id=1, exit_code=0.
REQ-041 No events, TIMEOUT_CYCLES=40 -> status=11, fail=1 when cycle_count=40; stop after DRAIN_CYCLES.
REQ-042 trap[0] held high through HOLD -> no fire; later fall then rise -> status=10 trap_id=0.
REQ-043 Reset pulsed low during DRAIN -> all outputs to reset values immediately, HOLD resequences.
